// File: rtl/tag_checker.sv
// tag_checker
//   Pops one request from the tag FIFO, consumes the matching metadata burst
//   from the memory controller R channel and reports one hit/miss result per
//   request. Requests are handled strictly in order, one at a time.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   tag_fifo_*          tag FIFO pop interface; entry is {wr, tid, addr}
//   rid_i .. rready_o   R channel (only the first beat carries metadata)
//   res_*               result handshake towards cache control
//   hit_cnt_o/miss_cnt_o  saturating result counters (TAG_CHECKER_STAT_EN only)
//
// Optional feature macro: TAG_CHECKER_STAT_EN
//
// state  | meaning
// IDLE   | waiting for a non-empty tag FIFO
// POP    | one-cycle FIFO read strobe
// LOAD   | FIFO data valid, capture the request entry
// WAIT_R | accept first R beat, evaluate tag match
// DRAIN  | discard remaining beats of the burst
// RESP   | hold result until accepted
module tag_checker #(
  parameter int ADDR_WIDTH   = 64,
  parameter int TID_WIDTH    = 10,
  parameter int INDEX_WIDTH  = 10,
  parameter int OFFSET_WIDTH = 6,
  parameter int DATA_WIDTH   = 512,
  parameter int ID_WIDTH     = 16,
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tag_fifo_empty_i,
  output logic                          tag_fifo_rden_o,
  input  logic [ADDR_WIDTH+TID_WIDTH:0] tag_fifo_data_i,
  input  logic [ID_WIDTH-1:0]           rid_i,
  input  logic [DATA_WIDTH-1:0]         rdata_i,
  input  logic                          rlast_i,
  input  logic                          rvalid_i,
  output logic                          rready_o,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic                          res_hit_o,
  output logic                          res_wr_o,
  output logic                          res_dirty_o,
  output logic [TID_WIDTH-1:0]          res_tid_o,
  output logic [ADDR_WIDTH-1:0]         res_addr_o,
  output logic [TAG_WIDTH-1:0]          res_victim_tag_o
`ifdef TAG_CHECKER_STAT_EN
  ,
  output logic [31:0]                   hit_cnt_o,
  output logic [31:0]                   miss_cnt_o
`endif
);

  localparam int VALID_BIT = 63;
  localparam int DIRTY_BIT = 62;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_WAIT_R,
    ST_DRAIN,
    ST_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   wr_q, wr_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   hit_q, hit_d;
  logic                   dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0]   victim_q, victim_d;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [TAG_WIDTH-1:0]   beat_tag;

  // Ordering is implicit, so rid and the non-metadata data bits are ignored.
  logic unused_bits;
  assign unused_bits = ^{rid_i, rdata_i[DATA_WIDTH-1:VALID_BIT+1],
                         rdata_i[DIRTY_BIT-1:TAG_WIDTH]};

  assign req_tag  = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign beat_tag = rdata_i[TAG_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      tid_q    <= '0;
      addr_q   <= '0;
      hit_q    <= 1'b0;
      dirty_q  <= 1'b0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      tid_q    <= tid_d;
      addr_q   <= addr_d;
      hit_q    <= hit_d;
      dirty_q  <= dirty_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    tid_d    = tid_q;
    addr_d   = addr_q;
    hit_d    = hit_q;
    dirty_d  = dirty_q;
    victim_d = victim_q;
    case (state_q)
      ST_IDLE: begin
        if (!tag_fifo_empty_i) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        {wr_d, tid_d, addr_d} = tag_fifo_data_i;
        state_d = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (rvalid_i) begin
          hit_d    = rdata_i[VALID_BIT] && (beat_tag == req_tag);
          dirty_d  = rdata_i[DIRTY_BIT];
          victim_d = beat_tag;
          state_d  = rlast_i ? ST_RESP : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rvalid_i && rlast_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // POP is only entered from IDLE after seeing a non-empty FIFO, and lasts one
  // cycle, so the strobe cannot double-pop.
  assign tag_fifo_rden_o  = (state_q == ST_POP);
  assign rready_o         = (state_q == ST_WAIT_R) || (state_q == ST_DRAIN);
  assign res_valid_o      = (state_q == ST_RESP);
  assign res_hit_o        = hit_q;
  assign res_wr_o         = wr_q;
  assign res_dirty_o      = dirty_q;
  assign res_tid_o        = tid_q;
  assign res_addr_o       = addr_q;
  assign res_victim_tag_o = victim_q;

`ifdef TAG_CHECKER_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (res_valid_o && res_ready_i) begin
      if (res_hit_o) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tag_checker.sv
module tb_tag_checker;

  localparam int AW = 64;
  localparam int TW = 10;
  localparam int DW = 512;
  localparam int IW = 16;
  localparam int GW = 48;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             rden;
  logic [AW+TW:0]   fifo_data = '0;
  logic [IW-1:0]    rid = '0;
  logic [DW-1:0]    rdata = '0;
  logic             rlast = 1'b0;
  logic             rvalid = 1'b0;
  logic             rready;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             res_hit, res_wr, res_dirty;
  logic [TW-1:0]    res_tid;
  logic [AW-1:0]    res_addr;
  logic [GW-1:0]    res_vtag;
`ifdef TAG_CHECKER_STAT_EN
  logic [31:0]      hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          hit, wr, dirty;
    logic [TW-1:0] tid;
    logic [AW-1:0] addr;
    logic [GW-1:0] vtag;
    int            lat;
    bit            stable_ok, quiet_ok, no_dbl_pop, timeout;
  } txn_t;

  tag_checker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tag_fifo_empty_i (fifo_empty),
    .tag_fifo_rden_o  (rden),
    .tag_fifo_data_i  (fifo_data),
    .rid_i            (rid),
    .rdata_i          (rdata),
    .rlast_i          (rlast),
    .rvalid_i         (rvalid),
    .rready_o         (rready),
    .res_valid_o      (res_valid),
    .res_ready_i      (res_ready),
    .res_hit_o        (res_hit),
    .res_wr_o         (res_wr),
    .res_dirty_o      (res_dirty),
    .res_tid_o        (res_tid),
    .res_addr_o       (res_addr),
    .res_victim_tag_o (res_vtag)
`ifdef TAG_CHECKER_STAT_EN
    ,
    .hit_cnt_o        (hit_cnt),
    .miss_cnt_o       (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Request tag by plain arithmetic: drop the 16 index+offset bits.
  function automatic logic [GW-1:0] tag_of(input logic [AW-1:0] a);
    return GW'(a >> 16);
  endfunction

  // Drives one full request through FIFO, R channel and result handshake and
  // reports what was observed; the calling test decides what is expected.
  task automatic do_txn(input logic wr, input logic [TW-1:0] tid,
                        input logic [AW-1:0] addr, input logic v, input logic d,
                        input logic [GW-1:0] stag, input int nbeats,
                        input int hold, input int idle_pre, input bit gaps,
                        input bit pend_next, output txn_t r);
    logic [DW-1:0] meta;
    int idx, guard;
    bit acc;
    r.hit = 0; r.wr = 0; r.dirty = 0; r.tid = '0; r.addr = '0; r.vtag = '0;
    r.lat = 0; r.stable_ok = 1; r.quiet_ok = 1; r.no_dbl_pop = 1; r.timeout = 0;
    meta = rand512();
    meta[63] = v;
    meta[62] = d;
    meta[GW-1:0] = stag;
    rvalid = 1'b1; rdata = meta; rlast = (nbeats == 1);
    for (int i = 0; i < idle_pre; i++) begin
      if (rready !== 1'b0 || rden !== 1'b0) r.quiet_ok = 0;
      step();
    end
    fifo_empty = 1'b0;
    guard = 0;
    while (rden !== 1'b1 && guard < 20) begin
      if (rready !== 1'b0) r.quiet_ok = 0;
      step(); r.lat++; guard++;
    end
    if (guard >= 20) begin
      r.timeout = 1; fifo_empty = 1'b1; rvalid = 1'b0;
      return;
    end
    step(); r.lat++;
    fifo_data = {wr, tid, addr};
    fifo_empty = 1'b1;
    if (rden !== 1'b0) r.no_dbl_pop = 0;
    idx = 0; guard = 0;
    while (idx < nbeats && guard < 200) begin
      rdata  = (idx == 0) ? meta : rand512();
      rlast  = (idx == nbeats - 1);
      rvalid = !(gaps && $urandom_range(0, 3) == 0);
      acc    = rready && rvalid;
      step(); r.lat++; guard++;
      if (acc) idx++;
    end
    rvalid = 1'b0; rlast = 1'b0;
    guard = 0;
    while (res_valid !== 1'b1 && guard < 50) begin
      step(); r.lat++; guard++;
    end
    if (guard >= 50) begin
      r.timeout = 1;
      return;
    end
    r.hit = res_hit; r.wr = res_wr; r.dirty = res_dirty;
    r.tid = res_tid; r.addr = res_addr; r.vtag = res_vtag;
    if (pend_next) fifo_empty = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (res_valid !== 1'b1 || rden !== 1'b0 || rready !== 1'b0 ||
          {res_hit, res_wr, res_dirty, res_tid, res_addr, res_vtag} !==
          {r.hit, r.wr, r.dirty, r.tid, r.addr, r.vtag})
        r.stable_ok = 0;
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    fifo_empty = 1'b1;
    if (res_valid !== 1'b0 || rden !== 1'b0) r.stable_ok = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({rden, rready, res_valid, res_hit, res_wr, res_dirty} !== 6'b0 ||
        res_tid !== '0 || res_addr !== '0 || res_vtag !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rden=%0b rready=%0b valid=%0b hit=%0b tid=%0h addr=%0h vtag=%0h want all 0",
               rden, rready, res_valid, res_hit, res_tid, res_addr, res_vtag);
    end
`ifdef TAG_CHECKER_STAT_EN
    n_checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", hit_cnt, miss_cnt);
    end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read_hit();
    txn_t r;
    do_txn(1'b0, 10'd5, 64'h0000_1234_5678_0040, 1'b1, 1'b0, 48'h0000_1234_5678,
           1, 0, 0, 0, 0, r);
    n_checks++;
    if (r.timeout || r.lat != 4) begin
      n_fail++; $display("FAIL read_hit_latency got %0d (timeout=%0b) want 4", r.lat, r.timeout);
    end
    n_checks++;
    if ({r.hit, r.wr, r.dirty, r.tid} !== {1'b1, 1'b0, 1'b0, 10'd5}) begin
      n_fail++; $display("FAIL read_hit_fields got hit=%0b wr=%0b dirty=%0b tid=%0d want 1 0 0 5",
                         r.hit, r.wr, r.dirty, r.tid);
    end
    n_checks++;
    if (r.addr !== 64'h0000_1234_5678_0040 || r.vtag !== 48'h0000_1234_5678) begin
      n_fail++; $display("FAIL read_hit_addr got addr=%h vtag=%h", r.addr, r.vtag);
    end
  endtask

  task automatic test_write_miss();
    txn_t r;
    do_txn(1'b1, 10'd0, 64'hAAAA_0000_0000_0080, 1'b1, 1'b1, 48'hBBBB_0000_0000,
           1, 2, 0, 0, 0, r);
    n_checks++;
    if (r.timeout || {r.hit, r.wr, r.dirty, r.tid} !== {1'b0, 1'b1, 1'b1, 10'd0} ||
        r.vtag !== 48'hBBBB_0000_0000) begin
      n_fail++; $display("FAIL write_miss got hit=%0b wr=%0b dirty=%0b tid=%0d vtag=%h want 0 1 1 0 bbbb00000000",
                         r.hit, r.wr, r.dirty, r.tid, r.vtag);
    end
  endtask

  task automatic test_invalid_line();
    txn_t r;
    logic [AW-1:0] a;
    a = 64'h0123_4567_89AB_C000;
    do_txn(1'b0, 10'd3, a, 1'b0, 1'b0, tag_of(a), 1, 0, 0, 0, 0, r);
    n_checks++;
    if (r.timeout || r.hit !== 1'b0 || r.vtag !== tag_of(a)) begin
      n_fail++; $display("FAIL invalid_line got hit=%0b vtag=%h want 0 %h", r.hit, r.vtag, tag_of(a));
    end
    // Single-bit tag difference must miss on a valid line.
    do_txn(1'b0, 10'd4, a, 1'b1, 1'b0, tag_of(a) ^ 48'h8000_0000_0000, 1, 0, 0, 0, 0, r);
    n_checks++;
    if (r.timeout || r.hit !== 1'b0) begin
      n_fail++; $display("FAIL tag_msb_diff got hit=%0b want 0", r.hit);
    end
  endtask

  task automatic test_multibeat_backpressure();
    txn_t r;
    logic [AW-1:0] a;
    a = 64'hFEDC_BA98_7654_3FC0;
    do_txn(1'b0, 10'd77, a, 1'b1, 1'b1, tag_of(a), 4, 10, 0, 0, 1, r);
    n_checks++;
    if (r.timeout || r.lat != 7) begin
      n_fail++; $display("FAIL multibeat_latency got %0d want 7", r.lat);
    end
    n_checks++;
    if ({r.hit, r.dirty, r.tid} !== {1'b1, 1'b1, 10'd77} || r.addr !== a) begin
      n_fail++; $display("FAIL multibeat_fields got hit=%0b dirty=%0b tid=%0d addr=%h",
                         r.hit, r.dirty, r.tid, r.addr);
    end
    n_checks++;
    if (!r.stable_ok || !r.no_dbl_pop) begin
      n_fail++; $display("FAIL multibeat_stable got stable=%0b single_pop=%0b want 1 1",
                         r.stable_ok, r.no_dbl_pop);
    end
  endtask

  task automatic test_early_r();
    txn_t r;
    logic [AW-1:0] a;
    a = 64'h0000_0000_DEAD_0000;
    do_txn(1'b1, 10'd1023, a, 1'b1, 1'b0, tag_of(a), 2, 0, 6, 0, 0, r);
    n_checks++;
    if (!r.quiet_ok) begin
      n_fail++; $display("FAIL early_r_quiet got rready/rden asserted while FIFO empty, want 0");
    end
    n_checks++;
    if (r.timeout || {r.hit, r.wr, r.tid} !== {1'b1, 1'b1, 10'd1023}) begin
      n_fail++; $display("FAIL early_r_result got hit=%0b wr=%0b tid=%0d want 1 1 1023", r.hit, r.wr, r.tid);
    end
  endtask

  task automatic test_random();
    txn_t r;
    logic [AW-1:0] a;
    logic [GW-1:0] st;
    logic v, d, w, exp_hit;
    logic [TW-1:0] t;
    for (int n = 0; n < 25; n++) begin
      a = {$urandom, $urandom};
      t = TW'($urandom);
      w = 1'($urandom);
      v = ($urandom_range(0, 3) != 0);
      d = 1'($urandom);
      st = ($urandom_range(0, 1) == 1) ? tag_of(a) : {16'($urandom), $urandom};
      exp_hit = v && (st == tag_of(a));
      do_txn(w, t, a, v, d, st, $urandom_range(1, 4), $urandom_range(0, 3), 0, 1, 0, r);
      n_checks++;
      if (r.timeout || {r.hit, r.wr, r.dirty, r.tid} !== {exp_hit, w, d, t} ||
          r.addr !== a || r.vtag !== st || !r.stable_ok) begin
        n_fail++;
        $display("FAIL random_%0d got hit=%0b wr=%0b dirty=%0b tid=%0d addr=%h vtag=%h want %0b %0b %0b %0d %h %h",
                 n, r.hit, r.wr, r.dirty, r.tid, r.addr, r.vtag, exp_hit, w, d, t, a, st);
      end
    end
  endtask

  task automatic run_hits(input int nh, input int nm);
    txn_t r;
    logic [AW-1:0] a;
    logic want;
    for (int n = 0; n < nh + nm; n++) begin
      a = {$urandom, $urandom};
      want = (n < nh);
      do_txn(1'b0, TW'(n), a, 1'b1, 1'b0, want ? tag_of(a) : ~tag_of(a), 1, 1, 0, 0, 0, r);
      n_checks++;
      if (r.timeout || r.hit !== want) begin
        n_fail++; $display("FAIL stat_txn_%0d got hit=%0b want %0b", n, r.hit, want);
      end
    end
  endtask

  task automatic test_stats_reset_mid_drain();
    logic [DW-1:0] meta;
    int guard;
    run_hits(1, 1);
`ifdef TAG_CHECKER_STAT_EN
    n_checks++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      n_fail++; $display("FAIL stat_pre got %0d/%0d want 1/1", hit_cnt, miss_cnt);
    end
`endif
    meta = rand512();
    meta[63] = 1'b1;
    fifo_empty = 1'b0;
    guard = 0;
    while (rden !== 1'b1 && guard < 20) begin step(); guard++; end
    step();
    fifo_data = {1'b0, 10'd9, 64'h0000_0000_0001_0000};
    fifo_empty = 1'b1;
    rvalid = 1'b1; rlast = 1'b0; rdata = meta;
    step();
    step();
    rdata = rand512();
    step();
    n_checks++;
    if (guard >= 20 || rready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_drain_state got rready=%0b valid=%0b want 1 0", rready, res_valid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (res_valid !== 1'b0 || rready !== 1'b0 || rden !== 1'b0) begin
      n_fail++; $display("FAIL after_reset got valid=%0b rready=%0b rden=%0b want 0 0 0",
                         res_valid, rready, rden);
    end
`ifdef TAG_CHECKER_STAT_EN
    n_checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_fail++; $display("FAIL stat_cleared got %0d/%0d want 0/0", hit_cnt, miss_cnt);
    end
`endif
    step();
    n_checks++;
    if (rready !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_idle got rready=%0b want 0", rready);
    end
    rvalid = 1'b0;
    step();
    run_hits(3, 2);
`ifdef TAG_CHECKER_STAT_EN
    n_checks++;
    if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2) begin
      n_fail++; $display("FAIL stat_counts got %0d/%0d want 3/2", hit_cnt, miss_cnt);
    end
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_hit();
    test_write_miss();
    test_invalid_line();
    test_multibeat_backpressure();
    test_early_r();
    test_random();
    test_stats_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
